plot_stream_sink: RTL and testbench



---
 rtl/plot_stream_sink.sv | 162 ++++++++++++++++
 tb/tb_plot_stream_sink.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_stream_sink.sv
// plot_stream_sink
// Receiving end of the (x, y, colour, plot) pixel stream. In-range pixels are
// converted to linear framebuffer addresses (y*160 + x) and queued. They are
// written to a 160x120, 3-bit colour memory only on edges where the scan-out
// arbiter grants the write port. Off-screen pixels are consumed, not written,
// and counted in a saturating counter.
//
// Ports
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   x, y        pixel column / row
//   colour      pixel colour {R,G,B}
//   plot        pixel valid; a transfer happens when plot && plot_ready
//   plot_ready  sink can accept a pixel this cycle
//   mem_grant   arbiter allows a framebuffer write on this edge
//   mem_addr    linear framebuffer address of the current write
//   mem_data    colour of the current write
//   mem_wren    one-cycle write strobe
//   clip_count  saturating count of clipped pixels
//   busy        pixels in flight or a write in progress
module plot_stream_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int X_MAX      = 160,
    parameter int Y_MAX      = 120
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    output logic        plot_ready,
    input  logic        mem_grant,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_wren,
    output logic [7:0]  clip_count,
    output logic        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    // Stage A: one registered pixel between the input and the FIFO
    logic        r_a_valid;
    logic [14:0] r_a_addr;
    logic [2:0]  r_a_colour;

    // FIFO of {addr, colour}
    logic [17:0]   r_fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_fifo_count;

    logic        w_transfer;
    logic        w_in_range;
    logic        w_accept_in;
    logic        w_clip;
    logic        w_push;
    logic        w_pop;
    logic [14:0] w_addr;
    logic [CW:0] w_in_flight;
    logic [17:0] w_head;

    assign w_transfer  = plot && plot_ready;
    assign w_in_range  = ({24'd0, x} < 32'(X_MAX)) && ({25'd0, y} < 32'(Y_MAX));
    assign w_accept_in = w_transfer && w_in_range;
    assign w_clip      = w_transfer && !w_in_range;

    // y*160 + x as two shifts; the largest on-screen result (19199) fits in 15 bits
    assign w_addr = ({8'd0, y} << 3'd7) + ({8'd0, y} << 3'd5) + {7'd0, x};

    // Stage A always empties into the FIFO on the following edge, so the
    // push strobe is simply its valid flag.
    assign w_push = r_a_valid;
    // Only entries already in the FIFO can be popped; a pixel still in
    // stage A waits one more edge, which gives the two-cycle minimum latency.
    assign w_pop  = (r_fifo_count != CW'(0)) && mem_grant;

    assign w_in_flight = {1'b0, r_fifo_count} + {{CW{1'b0}}, r_a_valid};
    // Gated by reset_n so the source sees no room while the sink is held in reset
    assign plot_ready  = reset_n && (w_in_flight < DEPTH_L);
    assign busy        = r_a_valid || (r_fifo_count != CW'(0)) || mem_wren;
    assign w_head      = r_fifo_mem[r_rd_ptr];

    // Stage A register: load on an in-range transfer, otherwise drain into the FIFO
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_valid  <= 1'b0;
            r_a_addr   <= 15'd0;
            r_a_colour <= 3'd0;
        end else if (w_accept_in) begin
            r_a_valid  <= 1'b1;
            r_a_addr   <= w_addr;
            r_a_colour <= colour;
        end else begin
            r_a_valid  <= 1'b0;
        end
    end

    // FIFO storage and write pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_mem[i] <= 18'd0;
            end
            r_wr_ptr <= PW'(0);
        end else if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_a_addr, r_a_colour};
            r_wr_ptr             <= r_wr_ptr + PW'(1);
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // FIFO read pointer and occupancy; a simultaneous push and pop cancel out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr     <= PW'(0);
            r_fifo_count <= CW'(0);
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CW'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CW'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // Framebuffer write port: address/data hold their last value between writes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr <= 15'd0;
            mem_data <= 3'd0;
            mem_wren <= 1'b0;
        end else if (w_pop) begin
            mem_addr <= w_head[17:3];
            mem_data <= w_head[2:0];
            mem_wren <= 1'b1;
        end else begin
            mem_wren <= 1'b0;
        end
    end

    // Saturating count of clipped (off-screen) transfers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clip_count <= 8'd0;
        end else if (w_clip && (clip_count != 8'd255)) begin
            clip_count <= clip_count + 8'd1;
        end else begin
            clip_count <= clip_count;
        end
    end

endmodule

// File: tb/tb_plot_stream_sink.sv
// Self-checking bench for plot_stream_sink: directed scenarios with literal
// expectations plus a random stream, all compared every cycle against a
// transaction-level reference (queue of accepted pixels with acceptance time).
module tb_plot_stream_sink;

    localparam int DEPTH = 4;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  x       = 8'd0;
    logic [6:0]  y       = 7'd0;
    logic [2:0]  colour  = 3'd0;
    logic        plot    = 1'b0;
    logic        mem_grant = 1'b0;
    logic        plot_ready;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  clip_count;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    plot_stream_sink #(.FIFO_DEPTH(DEPTH), .X_MAX(160), .Y_MAX(120)) dut (
        .clock(clock), .reset_n(reset_n), .x(x), .y(y), .colour(colour),
        .plot(plot), .plot_ready(plot_ready), .mem_grant(mem_grant),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .clip_count(clip_count), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int addr;
        int col;
        int t;
    } pix_t;

    pix_t q[$];
    int   now    = 0;
    bit   m_wren = 1'b0;
    int   m_addr = 0;
    int   m_data = 0;
    int   m_clip = 0;

    // A pixel accepted at edge t can be written at the first granted edge
    // >= t+2 once everything accepted before it has been written.
    initial begin
        pix_t p;
        bit   ready_pre;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                q.delete();
                m_wren = 1'b0;
                m_addr = 0;
                m_data = 0;
                m_clip = 0;
            end else begin
                ready_pre = (q.size() < DEPTH);
                m_wren = 1'b0;
                if (mem_grant && q.size() > 0 && q[0].t <= now - 2) begin
                    p = q.pop_front();
                    m_wren = 1'b1;
                    m_addr = p.addr;
                    m_data = p.col;
                end
                if (plot && ready_pre) begin
                    if (x < 8'd160 && y < 7'd120) begin
                        p.addr = int'(y) * 160 + int'(x);
                        p.col  = int'(colour);
                        p.t    = now;
                        q.push_back(p);
                    end else if (m_clip < 255) begin
                        m_clip++;
                    end
                end
                now++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clock);
            if (mem_wren) wr_count++;
            if (!reset_n) begin
                chk("rst_wren", int'(mem_wren), 0);
                chk("rst_ready", int'(plot_ready), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_clip", int'(clip_count), 0);
                chk("rst_addr", int'(mem_addr), 0);
            end else begin
                chk("wren", int'(mem_wren), int'(m_wren));
                chk("addr", int'(mem_addr), m_addr);
                chk("data", int'(mem_data), m_data);
                chk("clip", int'(clip_count), m_clip);
                chk("busy", int'(busy), int'(q.size() > 0 || m_wren));
                chk("ready", int'(plot_ready), int'(q.size() < DEPTH));
            end
        end
    end

    // Present one pixel and hold it until accepted (bounded); plot stays high
    task automatic send(input int px, input int py, input int pc);
        bit r;
        int n;
        n = 0;
        x = px[7:0];
        y = py[6:0];
        colour = pc[2:0];
        plot = 1'b1;
        do begin
            r = plot_ready;
            tick();
            n++;
        end while (!r && n < 50);
        chk("send_accept", int'(r), 1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int w0;
        int acc, inr, clp, cyc;
        bit r;
        bit px_in;

        #1 reset_n = 1'b0;
        tick();
        chk("reset_ready_low", int'(plot_ready), 0);
        chk("reset_addr", int'(mem_addr), 0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        tick();
        chk("ready_after_release", int'(plot_ready), 1);
        chk("busy_after_release", int'(busy), 0);

        // single pixel
        mem_grant = 1'b1;
        send(10, 2, 5);
        plot = 1'b0;
        tick();
        tick();
        chk("single_wren", int'(mem_wren), 1);
        chk("single_addr", int'(mem_addr), 330);
        chk("single_data", int'(mem_data), 5);
        tick();
        chk("single_wren_off", int'(mem_wren), 0);
        chk("single_busy_off", int'(busy), 0);

        // corners back-to-back
        send(0, 0, 1);
        send(159, 119, 6);
        plot = 1'b0;
        tick();
        chk("corner0_wren", int'(mem_wren), 1);
        chk("corner0_addr", int'(mem_addr), 0);
        tick();
        chk("corner1_wren", int'(mem_wren), 1);
        chk("corner1_addr", int'(mem_addr), 19199);
        chk("corner1_data", int'(mem_data), 6);
        repeat (3) tick();

        // clipping
        w0 = wr_count;
        send(160, 0, 2);
        chk("clip_ready0", int'(plot_ready), 1);
        send(0, 120, 2);
        chk("clip_ready1", int'(plot_ready), 1);
        send(255, 127, 2);
        chk("clip_ready2", int'(plot_ready), 1);
        send(1, 1, 4);
        plot = 1'b0;
        chk("clip_count3", int'(clip_count), 3);
        tick();
        tick();
        chk("clip_wr_wren", int'(mem_wren), 1);
        chk("clip_wr_addr", int'(mem_addr), 161);
        repeat (3) tick();
        chk("clip_single_write", wr_count - w0, 1);

        // backpressure
        mem_grant = 1'b0;
        for (int k = 0; k < 4; k++) send(20 + k, 5, k);
        chk("bp_ready_low", int'(plot_ready), 0);
        chk("bp_busy", int'(busy), 1);
        x = 8'd24; y = 7'd5; colour = 3'd4; plot = 1'b1;
        repeat (3) tick();
        chk("bp_still_low", int'(plot_ready), 0);
        w0 = wr_count;
        mem_grant = 1'b1;
        send(24, 5, 4);
        send(25, 5, 5);
        plot = 1'b0;
        repeat (8) tick();
        chk("bp_total_writes", wr_count - w0, 6);
        chk("bp_last_addr", int'(mem_addr), 5 * 160 + 25);

        // saturation then reset with pixels in flight
        for (int k = 0; k < 300; k++) send(200, 0, 0);
        plot = 1'b0;
        tick();
        chk("clip_saturated", int'(clip_count), 255);
        mem_grant = 1'b0;
        send(3, 3, 1);
        send(4, 4, 2);
        send(5, 5, 3);
        plot = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_clip", int'(clip_count), 0);
        chk("mid_rst_addr", int'(mem_addr), 0);
        chk("mid_rst_ready", int'(plot_ready), 0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        tick();
        chk("post_rst_ready", int'(plot_ready), 1);
        w0 = wr_count;
        mem_grant = 1'b1;
        repeat (5) tick();
        chk("post_rst_no_write", wr_count - w0, 0);

        // random stream
        acc = 0; inr = 0; clp = 0; cyc = 0;
        w0 = wr_count;
        while (acc < 1000 && cyc < 20000) begin
            x = 8'($urandom_range(0, 179));
            y = 7'($urandom_range(0, 129));
            colour = 3'($urandom_range(0, 7));
            plot = ($urandom_range(0, 9) < 7);
            mem_grant = 1'($urandom_range(0, 1));
            px_in = (x < 8'd160) && (y < 7'd120);
            r = plot && plot_ready;
            tick();
            cyc++;
            if (r) begin
                acc++;
                if (px_in) inr++;
                else if (clp < 255) clp++;
            end
        end
        plot = 1'b0;
        mem_grant = 1'b1;
        repeat (10) tick();
        chk("rand_accepted", acc, 1000);
        chk("rand_writes", wr_count - w0, inr);
        chk("rand_clip", int'(clip_count), clp);
        chk("rand_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
